me_search_ctrl: RTL and testbench

//  Sequencer for one block-matching search on the PE array (one PE per block column).
//  - Loads the current block: drives crt_keep low for BLK cycles, then high.
//  - Scans all (2*RANGE+1)^2 candidate displacements in raster order, issuing BLK reference rows per candidate.
//  - Accumulates the per-row AD sums returned by the PE adder tree and tracks the minimum SAD and its motion vector.
//  - Sits between the frame-buffer fetch unit and the MV output FIFO.

---
 rtl/me_pkg.sv | 35 +++
 rtl/me_sad_acc.sv | 132 +++++++++++++
 rtl/me_search_ctrl.sv | 165 ++++++++++++++++
 tb/tb_me_search_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared defaults, width helpers and state type for the ME search controller
//
// Purpose: common definitions imported by me_sad_acc and me_search_ctrl.
//   BLK_DEF / RANGE_DEF / ZBIAS_DEF : default block side, search range, zero-MV bias
//   row_w(blk)   : width of one row sum of BLK absolute differences
//   sad_w(blk)   : width of a full-block SAD (holds BLK*BLK*255 exactly)
//   idx_w(range) : width of a candidate index 0..2*RANGE
//   me_state_t   : sequencer states
package me_pkg;

    localparam int BLK_DEF   = 8;
    localparam int RANGE_DEF = 8;
    localparam int ZBIAS_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEARCH,
        DRAIN,
        RESULT
    } me_state_t;

    function automatic int row_w(input int blk);
        return 8 + $clog2(blk);
    endfunction

    function automatic int sad_w(input int blk);
        return 8 + 2 * $clog2(blk);
    endfunction

    function automatic int idx_w(input int range);
        return $clog2(2 * range + 1);
    endfunction

endpackage

// File: rtl/me_sad_acc.sv
// rtl/me_sad_acc.sv - receive-side SAD accumulator, best-candidate compare and receive counters
//
// Purpose: sums BLK returned row sums per candidate, compares each finished
// candidate against the running best and keeps the winning motion vector.
// Candidates are identified by counting returns, which arrive in issue order,
// so this block never looks at the issue-side counters.
// Optional feature: ME_ZERO_BIAS_EN - the centre candidate is compared as
// max(sad-ZBIAS,0) and that biased value is what min_sad reports.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clear        start of a new search: zero counters/accumulator, best = all ones
//   rx_en        row sums are accepted only while this is high
//   row_sad_i    one row sum from the PE adder tree
//   row_sad_vld  row_sad_i valid
//   rows_done    every row of every candidate has been received
//   min_sad      best (compared) SAD so far
//   mv_x, mv_y   motion vector of the best candidate, signed
module me_sad_acc
    import me_pkg::*;
#(
    parameter  int BLK   = BLK_DEF,
    parameter  int RANGE = RANGE_DEF,
    parameter  int ZBIAS = ZBIAS_DEF,
    localparam int ROW_W = row_w(BLK),
    localparam int SAD_W = sad_w(BLK),
    localparam int IDX_W = idx_w(RANGE),
    localparam int MV_W  = IDX_W + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    rx_en,
    input  logic [ROW_W-1:0]        row_sad_i,
    input  logic                    row_sad_vld,
    output logic                    rows_done,
    output logic [SAD_W-1:0]        min_sad,
    output logic signed [MV_W-1:0]  mv_x,
    output logic signed [MV_W-1:0]  mv_y
);

    localparam int CR_W  = $clog2(BLK);
    localparam int TOTAL = (2 * RANGE + 1) * (2 * RANGE + 1) * BLK;
    localparam int CNT_W = $clog2(TOTAL + 1);

    localparam logic [CR_W-1:0]       ROW_LAST = CR_W'(BLK - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(2 * RANGE);
    localparam logic [IDX_W-1:0]      CENTRE   = IDX_W'(RANGE);
    localparam logic signed [MV_W-1:0] RANGE_S = MV_W'(RANGE);

`ifdef ME_ZERO_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif
    // A zero bias turns the centre clamp into a pass-through, so the compare
    // path is the same in both builds.
    localparam logic [SAD_W-1:0] CENTRE_BIAS = BIAS_EN ? SAD_W'(ZBIAS) : '0;

    logic [SAD_W-1:0]        acc;
    logic [SAD_W-1:0]        sad;
    logic [SAD_W-1:0]        cmp_sad;
    logic [CR_W-1:0]         rrow;
    logic [IDX_W-1:0]        rx;
    logic [IDX_W-1:0]        ry;
    logic [CNT_W-1:0]        rcnt;
    logic                    take;
    logic                    cand_end;
    logic                    is_centre;
    logic                    better;
    logic signed [MV_W-1:0]  cand_mv_x;
    logic signed [MV_W-1:0]  cand_mv_y;

    assign take      = rx_en && row_sad_vld;
    assign cand_end  = (rrow == ROW_LAST);
    assign is_centre = (rx == CENTRE) && (ry == CENTRE);
    assign sad       = acc + SAD_W'(row_sad_i);
    assign cand_mv_x = signed'({1'b0, rx}) - RANGE_S;
    assign cand_mv_y = signed'({1'b0, ry}) - RANGE_S;
    assign rows_done = (rcnt == CNT_W'(TOTAL));

    always_comb begin
        cmp_sad = sad;
        if (is_centre) begin
            cmp_sad = (sad > CENTRE_BIAS) ? (sad - CENTRE_BIAS) : '0;
        end
    end

    // Strict less-than: on a tie the earlier raster candidate stays best.
    assign better = (cmp_sad < min_sad);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            rrow    <= '0;
            rx      <= '0;
            ry      <= '0;
            rcnt    <= '0;
            min_sad <= '0;
            mv_x    <= '0;
            mv_y    <= '0;
        end else if (clear) begin
            acc     <= '0;
            rrow    <= '0;
            rx      <= '0;
            ry      <= '0;
            rcnt    <= '0;
            min_sad <= '1;
        end else if (take) begin
            rcnt <= rcnt + CNT_W'(1);
            if (cand_end) begin
                acc  <= '0;
                rrow <= '0;
                if (rx == IDX_LAST) begin
                    rx <= '0;
                    ry <= (ry == IDX_LAST) ? '0 : ry + IDX_W'(1);
                end else begin
                    rx <= rx + IDX_W'(1);
                end
                if (better) begin
                    min_sad <= cmp_sad;
                    mv_x    <= cand_mv_x;
                    mv_y    <= cand_mv_y;
                end
            end else begin
                acc  <= sad;
                rrow <= rrow + CR_W'(1);
            end
        end
    end

endmodule

// File: rtl/me_search_ctrl.sv
// rtl/me_search_ctrl.sv - block-matching search sequencer for the PE array
//
// Purpose: loads the current block into the PEs, issues BLK reference rows for
// every candidate displacement in raster order, then reports the best motion
// vector once every row sum has come back.
// Optional feature: ME_ZERO_BIAS_EN (handled in me_sad_acc) biases the centre
// candidate by ZBIAS.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           begin a search (IDLE only)
//   busy            high in every state except IDLE
//   crt_keep        low only while the current block is loaded
//   crt_row         current-block row being loaded
//   row_valid       reference-row fetch request; row_ready accepts it
//   cand_x, cand_y  candidate indices 0..2*RANGE of the requested row
//   pre_row         row within the candidate block
//   row_sad_i       returned row sum, qualified by row_sad_vld (issue order)
//   res_valid       result available; res_ready consumes it
//   mv_x, mv_y      best motion vector, signed
//   min_sad         SAD of the best candidate
module me_search_ctrl
    import me_pkg::*;
#(
    parameter  int BLK   = BLK_DEF,
    parameter  int RANGE = RANGE_DEF,
    parameter  int ZBIAS = ZBIAS_DEF,
    localparam int ROW_W = row_w(BLK),
    localparam int SAD_W = sad_w(BLK),
    localparam int IDX_W = idx_w(RANGE),
    localparam int MV_W  = IDX_W + 1,
    localparam int CR_W  = $clog2(BLK)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    crt_keep,
    output logic [CR_W-1:0]         crt_row,
    output logic                    row_valid,
    input  logic                    row_ready,
    output logic [IDX_W-1:0]        cand_x,
    output logic [IDX_W-1:0]        cand_y,
    output logic [CR_W-1:0]         pre_row,
    input  logic [ROW_W-1:0]        row_sad_i,
    input  logic                    row_sad_vld,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [MV_W-1:0]  mv_x,
    output logic signed [MV_W-1:0]  mv_y,
    output logic [SAD_W-1:0]        min_sad
);

    localparam logic [CR_W-1:0]  ROW_LAST = CR_W'(BLK - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * RANGE);

    me_state_t state;
    me_state_t state_n;

    logic issue;
    logic last_issue;
    logic clear;
    logic rx_en;
    logic rows_done;

    assign issue      = row_valid && row_ready;
    assign last_issue = (pre_row == ROW_LAST) && (cand_x == IDX_LAST) && (cand_y == IDX_LAST);
    assign clear      = (state == IDLE) && start;
    // Row sums outside SEARCH/DRAIN cannot belong to the current search.
    assign rx_en      = (state == SEARCH) || (state == DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            crt_row <= '0;
            pre_row <= '0;
            cand_x  <= '0;
            cand_y  <= '0;
        end else begin
            state <= state_n;
            // BLK is a power of two, so the row counter wraps back to 0
            // exactly as LOAD ends.
            if (state == LOAD) begin
                crt_row <= crt_row + CR_W'(1);
            end
            if (clear) begin
                pre_row <= '0;
                cand_x  <= '0;
                cand_y  <= '0;
            end else if (issue) begin
                if (pre_row == ROW_LAST) begin
                    pre_row <= '0;
                    if (cand_x == IDX_LAST) begin
                        cand_x <= '0;
                        cand_y <= (cand_y == IDX_LAST) ? '0 : cand_y + IDX_W'(1);
                    end else begin
                        cand_x <= cand_x + IDX_W'(1);
                    end
                end else begin
                    pre_row <= pre_row + CR_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_n   = state;
        busy      = 1'b1;
        crt_keep  = 1'b1;
        row_valid = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                crt_keep = 1'b0;
                if (crt_row == ROW_LAST) begin
                    state_n = SEARCH;
                end
            end
            SEARCH: begin
                row_valid = 1'b1;
                if (row_ready && last_issue) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (rows_done) begin
                    state_n = RESULT;
                end
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    me_sad_acc #(
        .BLK   (BLK),
        .RANGE (RANGE),
        .ZBIAS (ZBIAS)
    ) u_sad_acc (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .rx_en       (rx_en),
        .row_sad_i   (row_sad_i),
        .row_sad_vld (row_sad_vld),
        .rows_done   (rows_done),
        .min_sad     (min_sad),
        .mv_x        (mv_x),
        .mv_y        (mv_y)
    );

endmodule

// File: tb/tb_me_search_ctrl.sv
// tb/tb_me_search_ctrl.sv - self-checking bench for me_search_ctrl (BLK=4, RANGE=2)
module tb_me_search_ctrl;

    localparam int BLK   = 4;
    localparam int RANGE = 2;
    localparam int ZBIAS = 16;
    localparam int NC    = 2 * RANGE + 1;
    localparam int LAT   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              crt_keep;
    logic [1:0]        crt_row;
    logic              row_valid;
    logic              row_ready;
    logic [2:0]        cand_x;
    logic [2:0]        cand_y;
    logic [1:0]        pre_row;
    logic [9:0]        row_sad_i;
    logic              row_sad_vld;
    logic              res_valid;
    logic              res_ready;
    logic signed [3:0] mv_x;
    logic signed [3:0] mv_y;
    logic [11:0]       min_sad;

    int total = 0;
    int bad   = 0;
    int mode  = 0;
    int seed  = 0;
    bit ready_mode = 1'b0;
    int issue_cnt  = 0;
    int ex, ey, er;
    logic       pv [LAT];
    logic [9:0] pd [LAT];

    typedef struct {
        int mx;
        int my;
        int sad;
    } res_t;
    res_t sb[$];

    always #5 clk = ~clk;

    me_search_ctrl #(
        .BLK   (BLK),
        .RANGE (RANGE),
        .ZBIAS (ZBIAS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .crt_keep    (crt_keep),
        .crt_row     (crt_row),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .cand_x      (cand_x),
        .cand_y      (cand_y),
        .pre_row     (pre_row),
        .row_sad_i   (row_sad_i),
        .row_sad_vld (row_sad_vld),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .mv_x        (mv_x),
        .mv_y        (mv_y),
        .min_sad     (min_sad)
    );

    task automatic chk(input string tag, input integer obs, input integer exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rowsum(input int m, input int x, input int y, input int r);
        case (m)
            0:       return (x == 3 && y == 1) ? 0 : 10;
            1:       return 5;
            2:       return (x == RANGE && y == RANGE) ? ((r % 2 == 1) ? 8 : 7) : 5;
            default: return ((x * 73 + y * 151 + r * 29 + seed * 7) % 97) + 60;
        endcase
    endfunction

    function automatic res_t model(input int m);
        res_t b;
        int   s;
        int   c;
        b.sad = 32'h7fff_ffff;
        b.mx  = 0;
        b.my  = 0;
        for (int y = 0; y < NC; y++) begin
            for (int x = 0; x < NC; x++) begin
                s = 0;
                for (int r = 0; r < BLK; r++) s += rowsum(m, x, y, r);
                c = s;
`ifdef ME_ZERO_BIAS_EN
                if (x == RANGE && y == RANGE) c = (s > ZBIAS) ? s - ZBIAS : 0;
`endif
                if (c < b.sad) begin
                    b.sad = c;
                    b.mx  = x - RANGE;
                    b.my  = y - RANGE;
                end
            end
        end
        return b;
    endfunction

    // Fetch unit + PE array model: checks the issue order against its own
    // raster counters and returns row sums after a fixed latency.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                pv[k] = 1'b0;
                pd[k] = '0;
            end
            ex = 0; ey = 0; er = 0;
            issue_cnt   = 0;
            row_sad_vld = 1'b0;
            row_sad_i   = '0;
            row_ready   = 1'b1;
        end else begin
            automatic bit iss = row_valid && row_ready;
            row_sad_vld = pv[LAT-1];
            row_sad_i   = pd[LAT-1];
            for (int k = LAT - 1; k > 0; k--) begin
                pv[k] = pv[k-1];
                pd[k] = pd[k-1];
            end
            pv[0] = iss;
            pd[0] = '0;
            if (iss) begin
                chk("issue_cand_x", cand_x, ex);
                chk("issue_cand_y", cand_y, ey);
                chk("issue_pre_row", pre_row, er);
                pd[0] = 10'(rowsum(mode, ex, ey, er));
                issue_cnt++;
                er++;
                if (er == BLK) begin
                    er = 0;
                    ex++;
                    if (ex == NC) begin
                        ex = 0;
                        ey++;
                    end
                end
            end
            if (!busy) begin
                ex = 0; ey = 0; er = 0;
                issue_cnt = 0;
            end
            row_ready = ready_mode ? !row_ready : 1'b1;
        end
    end

    task automatic run(input int m, input bit tog, input int hold);
        res_t e;
        mode       = m;
        ready_mode = tog;
        sb.push_back(model(m));
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < BLK; i++) begin
            chk("load_crt_keep", crt_keep, 0);
            chk("load_crt_row", crt_row, i);
            @(negedge clk);
        end
        chk("search_crt_keep", crt_keep, 1);
        chk("search_row_valid", row_valid, 1);
        chk("first_cand_x", cand_x, 0);
        chk("first_cand_y", cand_y, 0);
        chk("first_pre_row", pre_row, 0);
        for (int n = 0; n < 3000 && !res_valid; n++) @(negedge clk);
        chk("res_valid_timeout", res_valid, 1);
        e = sb.pop_front();
        if (hold > 0) start = 1'b1;
        for (int h = 0; h < hold; h++) begin
            chk("hold_res_valid", res_valid, 1);
            chk("hold_mv_x", mv_x, e.mx);
            chk("hold_mv_y", mv_y, e.my);
            chk("hold_min_sad", min_sad, e.sad);
            chk("hold_crt_keep", crt_keep, 1);
            @(negedge clk);
        end
        start = 1'b0;
        chk("mv_x", mv_x, e.mx);
        chk("mv_y", mv_y, e.my);
        chk("min_sad", min_sad, e.sad);
        chk("issue_count", issue_cnt, NC * NC * BLK);
        chk("result_row_valid", row_valid, 0);
        res_ready = 1'b1;
        @(negedge clk) res_ready = 1'b0;
        chk("post_res_valid", res_valid, 0);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_crt_keep", crt_keep, 1);
        chk("rst_crt_row", crt_row, 0);
        chk("rst_row_valid", row_valid, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_mv_x", mv_x, 0);
        chk("rst_mv_y", mv_y, 0);
        chk("rst_min_sad", min_sad, 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        // one cheap candidate at (3,1)
        run(0, 1'b0, 0);
        // all equal: earliest raster candidate wins
        run(1, 1'b0, 0);

        // reset in the middle of SEARCH
        mode = 2;
        ready_mode = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_in_search", row_valid, 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_crt_keep", crt_keep, 1);
        chk("abort_row_valid", row_valid, 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        // centre candidate slightly worse than the rest
        run(2, 1'b0, 0);
        // throttled fetch, held result, start ignored while busy
        run(0, 1'b1, 10);
        // pseudo-random row sums
        seed = 1;
        run(3, 1'b0, 0);
        seed = 5;
        run(3, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
